// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

endpackage

// File: rtl/dmem_req_check.sv
// Request legality check: size, natural alignment and range, plus the per-lane enable mask.
module dmem_req_check
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic [63:0] addr_i,
  input  logic [3:0]  size_i,
  output logic        err_o,
  output logic [7:0]  lane_en_o
);

  logic        size_ok;
  logic        misaligned;
  logic        oob;
  logic [64:0] end_addr;

  always_comb begin
    size_ok    = (size_i == SZ_B) || (size_i == SZ_H) || (size_i == SZ_W) || (size_i == SZ_D);
    misaligned = (addr_i[3:0] & (size_i - 4'd1)) != 4'd0;
    // 65-bit sum so a near-2^64 address cannot wrap back into range.
    end_addr   = {1'b0, addr_i} + 65'(size_i);
    oob        = end_addr > 65'(MEM_BYTES);
    err_o      = !size_ok || misaligned || oob;
    for (int k = 0; k < 8; k++) begin
      lane_en_o[k] = !err_o && (4'(k) < size_i);
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle big-endian data memory with request/response valid-ready handshakes.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [3:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  mem [MEM_BYTES]
);

  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [63:0]   addr_q, addr_d;
  logic [3:0]    size_q, size_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [7:0]    mem_q [MEM_BYTES];
  logic [7:0]    mem_d [MEM_BYTES];

  logic          chk_err;
  logic [7:0]    lane_en;
  logic [AW-1:0] lane_idx [8];
  logic [2:0]    lane_sh [8];
  logic [7:0]    wr_byte [8];
  logic [63:0]   rd_data;

  dmem_req_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_check (
    .addr_i   (addr_q),
    .size_i   (size_q),
    .err_o    (chk_err),
    .lane_en_o(lane_en)
  );

  // Lane k is byte addr+k; it carries data byte (size-1-k), i.e. MSB first.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < 8; k++) begin
      lane_idx[k] = addr_q[AW-1:0] + AW'(k);
      lane_sh[k]  = 3'(size_q - 4'd1 - 4'(k));
      wr_byte[k]  = wdata_q[{lane_sh[k], 3'b000} +: 8];
      if (lane_en[k]) begin
        rd_data = {rd_data[55:0], mem_q[lane_idx[k]]};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_d   = mem_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BUSY;
          cnt_d   = CW'(LATENCY - 1);
          write_d = req_write;
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_wdata;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          err_d   = chk_err;
          rdata_d = (chk_err || write_q) ? '0 : rd_data;
          if (write_q && !chk_err) begin
            for (int k = 0; k < 8; k++) begin
              if (lane_en[k]) mem_d[lane_idx[k]] = wr_byte[k];
            end
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mem_q   <= '{default: 8'h00};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem        = mem_q;

endmodule
